// File: rtl/temp_avg_pkg.sv
// Shared types and constants for the multi-channel temperature averager.
package temp_avg_pkg;

   typedef enum logic [1:0] {IDLE, SAMPLE, CALC, EMIT} avg_state_t;

   localparam int unsigned TEMP_W = 9;
   typedef logic signed [TEMP_W-1:0] temp_t;

   // Default alarm limits in degrees
   localparam int T_LO_DEF = -40;
   localparam int T_HI_DEF = 85;

   // Sign glyphs used by the 7-segment and LCD formatting logic
   localparam logic [6:0] SEG_GLYPH_MINUS = 7'b0111111;  // only segment g lit (active-low)
   localparam logic [6:0] SEG_GLYPH_BLANK = 7'b1111111;
   localparam logic [7:0] LCD_GLYPH_MINUS = 8'h2D;
   localparam logic [7:0] LCD_GLYPH_PLUS  = 8'h2B;

endpackage

// File: rtl/temp_tick_gen.sv
// Sample-tick divider plus the seconds counter and minute pulse.
module temp_tick_gen #(
   parameter int unsigned TICK_DIV = 50_000_000,
   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
   input  logic       clk,
   input  logic       rst,
   output logic       tick,
   output logic [5:0] o_seg,
   output logic       min_pulse
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;

   assign tick = (cnt_q == CNT_LAST);

   // Free-running divider, restarts at zero after the terminal count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Seconds 0..59; min_pulse is high in the cycle o_seg shows the wrapped 0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_seg     <= '0;
         min_pulse <= 1'b0;
      end else begin
         min_pulse <= 1'b0;
         if (tick) begin
            if (o_seg == 6'd59) begin
               o_seg     <= '0;
               min_pulse <= 1'b1;
            end else begin
               o_seg <= o_seg + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/temp_avg_multi.sv
// Multi-channel moving-average temperature monitor with min/max, alarm and
// a valid/ready result stream, one result per channel per accepted tick.
module temp_avg_multi import temp_avg_pkg::*; #(
   parameter int unsigned CHANNELS  = 4,
   parameter int unsigned DATA_W    = 9,
   parameter int unsigned LOG_DEPTH = 3,
   parameter int unsigned TICK_DIV  = 50_000_000,
   parameter int          T_LO      = T_LO_DEF,
   parameter int          T_HI      = T_HI_DEF,
   localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic [CHANNELS*DATA_W-1:0]   temp_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [CH_W-1:0]              out_chan,
   output logic signed [DATA_W-1:0]     out_avg,
   output logic signed [DATA_W-1:0]     out_min,
   output logic signed [DATA_W-1:0]     out_max,
   output logic                         out_warm,
   output logic                         out_alarm,
   output logic                         overrun,
   output logic [5:0]                   o_seg,
   output logic                         min_pulse
);

   localparam int unsigned DEPTH = 1 << LOG_DEPTH;
   localparam int unsigned SUM_W = DATA_W + LOG_DEPTH;
   localparam logic [LOG_DEPTH:0]       FILL_FULL = (LOG_DEPTH + 1)'(DEPTH);
   localparam logic [CH_W-1:0]          LAST_CH   = CH_W'(CHANNELS - 1);
   localparam logic signed [DATA_W-1:0] LO_LIM    = DATA_W'(T_LO);
   localparam logic signed [DATA_W-1:0] HI_LIM    = DATA_W'(T_HI);
   localparam logic signed [DATA_W-1:0] POS_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] NEG_MAX   = -POS_MAX;

   logic tick;

   temp_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .o_seg     (o_seg),
      .min_pulse (min_pulse)
   );

   avg_state_t state_q, state_d;
   logic [CH_W-1:0] ch_q, ch_d;

   logic signed [DATA_W-1:0] smp_q   [CHANNELS][DEPTH];
   logic signed [SUM_W-1:0]  sum_q   [CHANNELS];
   logic [LOG_DEPTH-1:0]     wr_ptr_q[CHANNELS];
   logic [LOG_DEPTH:0]       fill_q  [CHANNELS];
   logic signed [DATA_W-1:0] min_q   [CHANNELS];
   logic signed [DATA_W-1:0] max_q   [CHANNELS];

   logic signed [DATA_W-1:0] temps[CHANNELS];
   logic signed [DATA_W-1:0] cur_x, cur_y, avg_w, new_min, new_max;
   logic signed [SUM_W-1:0]  sum_new, sum_sh;

   assign out_valid = (state_q == EMIT);

   // Datapath values for the channel currently being processed
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         temps[c] = temp_in[c*DATA_W +: DATA_W];
      end
      cur_x   = temps[ch_q];
      cur_y   = smp_q[ch_q][wr_ptr_q[ch_q]];
      sum_new = sum_q[ch_q] + SUM_W'(cur_x) - SUM_W'(cur_y);
      sum_sh  = sum_q[ch_q] >>> LOG_DEPTH;
      avg_w   = DATA_W'(sum_sh);
      new_min = (avg_w < min_q[ch_q]) ? avg_w : min_q[ch_q];
      new_max = (avg_w > max_q[ch_q]) ? avg_w : max_q[ch_q];
   end

   // Next-state logic; clear wins over everything including a pending tick
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      if (clear) begin
         state_d = IDLE;
         ch_d    = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (tick) begin
                  state_d = SAMPLE;
                  ch_d    = '0;
               end
            end
            SAMPLE: state_d = CALC;
            CALC:   state_d = EMIT;
            EMIT: begin
               if (out_ready) begin
                  if (ch_q == LAST_CH) begin
                     state_d = IDLE;
                  end else begin
                     ch_d    = ch_q + 1'b1;
                     state_d = SAMPLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ch_q    <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
      end
   end

   // Sample windows, running sums, fill counts, min/max and overrun flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst || clear) begin
         for (int c = 0; c < CHANNELS; c++) begin
            for (int d = 0; d < DEPTH; d++) begin
               smp_q[c][d] <= '0;
            end
            sum_q[c]    <= '0;
            wr_ptr_q[c] <= '0;
            fill_q[c]   <= '0;
            min_q[c]    <= POS_MAX;
            max_q[c]    <= NEG_MAX;
         end
         overrun <= 1'b0;
      end else begin
         if (tick && state_q != IDLE) begin
            overrun <= 1'b1;
         end
         if (state_q == SAMPLE) begin
            smp_q[ch_q][wr_ptr_q[ch_q]] <= cur_x;
            sum_q[ch_q]                 <= sum_new;
            wr_ptr_q[ch_q]              <= wr_ptr_q[ch_q] + 1'b1;
            if (fill_q[ch_q] != FILL_FULL) begin
               fill_q[ch_q] <= fill_q[ch_q] + 1'b1;
            end
         end
         if (state_q == CALC) begin
            min_q[ch_q] <= new_min;
            max_q[ch_q] <= new_max;
         end
      end
   end

   // Result registers, loaded in CALC and held through EMIT
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_chan  <= '0;
         out_avg   <= '0;
         out_min   <= '0;
         out_max   <= '0;
         out_warm  <= 1'b0;
         out_alarm <= 1'b0;
      end else if (!clear && state_q == CALC) begin
         out_chan  <= ch_q;
         out_avg   <= avg_w;
         out_min   <= new_min;
         out_max   <= new_max;
         out_warm  <= (fill_q[ch_q] == FILL_FULL);
         out_alarm <= (avg_w < LO_LIM) || (avg_w > HI_LIM);
      end
   end

endmodule

// File: tb/tb_temp_avg_multi.sv
// Self-checking bench: results compared against a windowed-average model.
module tb_temp_avg_multi;

   localparam int CH    = 2;
   localparam int DW    = 9;
   localparam int LD    = 2;
   localparam int TD    = 4;
   localparam int DEPTH = 1 << LD;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 clear;
   logic [CH*DW-1:0]     temp_in;
   logic                 out_valid;
   logic                 out_ready;
   logic [0:0]           out_chan;
   logic signed [DW-1:0] out_avg;
   logic signed [DW-1:0] out_min;
   logic signed [DW-1:0] out_max;
   logic                 out_warm;
   logic                 out_alarm;
   logic                 overrun;
   logic [5:0]           o_seg;
   logic                 min_pulse;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int tv[CH];
   int win[CH][DEPTH];
   int wptr[CH];
   int cnt[CH];
   int mn[CH];
   int mx[CH];
   int exp_ch;

   temp_avg_multi #(
      .CHANNELS  (CH),
      .DATA_W    (DW),
      .LOG_DEPTH (LD),
      .TICK_DIV  (TD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .temp_in   (temp_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_chan  (out_chan),
      .out_avg   (out_avg),
      .out_min   (out_min),
      .out_max   (out_max),
      .out_warm  (out_warm),
      .out_alarm (out_alarm),
      .overrun   (overrun),
      .o_seg     (o_seg),
      .min_pulse (min_pulse)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int floor_div(input int s, input int d);
      return (s >= 0) ? s / d : -((-s + d - 1) / d);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         for (int d = 0; d < DEPTH; d++) win[c][d] = 0;
         wptr[c] = 0;
         cnt[c]  = 0;
         mn[c]   = 1 << 20;
         mx[c]   = -(1 << 20);
      end
      exp_ch = 0;
   endtask

   task automatic set_temps(input int a, input int b);
      tv[0]   = a;
      tv[1]   = b;
      temp_in = {DW'(b), DW'(a)};
   endtask

   task automatic wait_valid(output bit ok);
      int k = 0;
      while (out_valid !== 1'b1 && k < 60) begin
         @(negedge clk);
         k++;
      end
      ok = (out_valid === 1'b1);
      if (!ok) check_eq("result_timeout", 0, 1);
   endtask

   // Consume one result (optionally stalling), compare with the model
   task automatic do_result(input int stall);
      int c, s, a;
      bit ok;
      if (stall > 0) out_ready = 1'b0;
      wait_valid(ok);
      if (!ok) begin
         out_ready = 1'b1;
         return;
      end
      c = exp_ch;
      win[c][wptr[c]] = tv[c];
      wptr[c] = (wptr[c] + 1) % DEPTH;
      if (cnt[c] < DEPTH) cnt[c]++;
      s = 0;
      for (int i = 0; i < DEPTH; i++) s += win[c][i];
      a = floor_div(s, DEPTH);
      if (a < mn[c]) mn[c] = a;
      if (a > mx[c]) mx[c] = a;
      check_eq("chan",  int'(out_chan), c);
      check_eq("avg",   int'(out_avg), a);
      check_eq("min",   int'(out_min), mn[c]);
      check_eq("max",   int'(out_max), mx[c]);
      check_eq("warm",  int'(out_warm), int'(cnt[c] == DEPTH));
      check_eq("alarm", int'(out_alarm), int'(a < -40 || a > 85));
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check_eq("stall_valid", int'(out_valid), 1);
         check_eq("stall_avg",   int'(out_avg), a);
         check_eq("stall_chan",  int'(out_chan), c);
      end
      if (stall > 0) begin
         check_eq("stall_overrun", int'(overrun), 1);
         out_ready = 1'b1;
      end
      @(negedge clk);
      check_eq("valid_drop", int'(out_valid), 0);
      exp_ch = (c + 1) % CH;
   endtask

   task automatic sweep(input int a, input int b);
      set_temps(a, b);
      do_result(0);
      do_result(0);
   endtask

   task automatic clear_pulse();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_reset();
      check_eq("clr_valid",   int'(out_valid), 0);
      check_eq("clr_overrun", int'(overrun), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit ok;
      int prev, gap, wraps;
      bit first, changed;

      rst       = 1'b0;
      clear     = 1'b0;
      out_ready = 1'b1;
      set_temps(25, -10);
      model_reset();
      repeat (3) @(negedge clk);
      check_eq("rst_valid",   int'(out_valid), 0);
      check_eq("rst_avg",     int'(out_avg), 0);
      check_eq("rst_min",     int'(out_min), 0);
      check_eq("rst_max",     int'(out_max), 0);
      check_eq("rst_seg",     int'(o_seg), 0);
      check_eq("rst_overrun", int'(overrun), 0);
      rst = 1'b1;

      // Warm-up from empty windows
      repeat (4) sweep(25, -10);

      // Window slide and alarm limits
      clear_pulse();
      repeat (4) sweep(20, -50);
      repeat (4) sweep(40, 90);

      // Randomised full-range samples
      for (int i = 0; i < 12; i++) begin
         sweep(int'($urandom_range(511)) - 256, int'($urandom_range(511)) - 256);
      end

      // Backpressure: hold ch0 for 10 cycles, a tick lands in the stall
      clear_pulse();
      set_temps(int'($urandom_range(200)) - 100, 7);
      do_result(10);
      do_result(0);

      // clear while a result is waiting
      out_ready = 1'b0;
      wait_valid(ok);
      clear_pulse();
      out_ready = 1'b1;
      repeat (2) sweep(-12, 64);

      // Seconds counter and minute pulse
      prev  = int'(o_seg);
      gap   = 0;
      wraps = 0;
      first = 1'b1;
      for (int i = 0; i < 62 * TD + 8; i++) begin
         @(negedge clk);
         gap++;
         changed = (int'(o_seg) != prev);
         if (changed) begin
            check_eq("sec_step", int'(o_seg), (prev + 1) % 60);
            if (!first) check_eq("sec_gap", gap, TD);
            first = 1'b0;
            gap   = 0;
            prev  = int'(o_seg);
            if (o_seg == 6'd0) wraps++;
         end
         check_eq("min_pulse", int'(min_pulse), int'(changed && o_seg == 6'd0));
      end
      check_eq("wraps_seen", int'(wraps >= 1), 1);

      // Asynchronous reset while a result is pending
      out_ready = 1'b0;
      wait_valid(ok);
      #2 rst = 1'b0;
      #1;
      check_eq("arst_valid", int'(out_valid), 0);
      check_eq("arst_chan",  int'(out_chan), 0);
      check_eq("arst_avg",   int'(out_avg), 0);
      check_eq("arst_min",   int'(out_min), 0);
      check_eq("arst_max",   int'(out_max), 0);
      check_eq("arst_warm",  int'(out_warm), 0);
      check_eq("arst_alarm", int'(out_alarm), 0);
      check_eq("arst_ovr",   int'(overrun), 0);
      check_eq("arst_seg",   int'(o_seg), 0);
      check_eq("arst_pulse", int'(min_pulse), 0);
      @(negedge clk);
      rst       = 1'b1;
      out_ready = 1'b1;
      model_reset();
      repeat (2) sweep(33, -77);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
